// File: rtl/degamma_linearizer_if.sv
// Pixel stream, knot-write and bank-commit signals of the degamma linearizer.
// The master drives pixels and knot updates; the slave returns linearised pixels.
interface degamma_linearizer_if #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned ADDR_WIDTH = 7
);
   logic                  inpvalid;
   logic                  sof;
   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] din1;
   logic [DATA_WIDTH-1:0] din2;
   logic                  lut_wr;
   logic [ADDR_WIDTH-1:0] lut_addr;
   logic [DATA_WIDTH-1:0] lut_wdata;
   logic                  lut_commit;
   logic                  outvalid;
   logic [DATA_WIDTH-1:0] dout0;
   logic [DATA_WIDTH-1:0] dout1;
   logic [DATA_WIDTH-1:0] dout2;
   logic                  commit_pending;

   modport master (
      output inpvalid, sof, din0, din1, din2, lut_wr, lut_addr, lut_wdata, lut_commit,
      input  outvalid, dout0, dout1, dout2, commit_pending
   );

   modport slave (
      input  inpvalid, sof, din0, din1, din2, lut_wr, lut_addr, lut_wdata, lut_commit,
      output outvalid, dout0, dout1, dout2, commit_pending
   );
endinterface

// File: rtl/degamma_linearizer.sv
// Gamma-to-linear mapping of a 3-plane pixel stream through a double-buffered 65-knot PWL curve.
// Three-stage pipeline (knot read, slope multiply, round/saturate); shadow bank swaps at a frame start.
module degamma_linearizer #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned FRAC_BITS  = 6,
   parameter int unsigned ADDR_WIDTH = 7
) (
   input logic                 clk,
   input logic                 rstn,
   degamma_linearizer_if.slave bus
);
   localparam int unsigned SegBits  = DATA_WIDTH - FRAC_BITS;
   localparam int unsigned NumKnots = (1 << SegBits) + 1;
   localparam int unsigned MaxInt   = (1 << DATA_WIDTH) - 1;
   localparam int unsigned DW       = DATA_WIDTH + 1;
   localparam int unsigned PW       = DATA_WIDTH + FRAC_BITS + 1;
   localparam int unsigned YW       = PW + 2;
   localparam int          RndInt   = 1 << (FRAC_BITS - 1);

   typedef enum logic [0:0] {StIdle, StPending} state_e;

   function automatic logic [DATA_WIDTH-1:0] ident_knot(input int unsigned idx);
      int unsigned v;
      v = idx << FRAC_BITS;
      if (v > MaxInt) v = MaxInt;
      return v[DATA_WIDTH-1:0];
   endfunction

   logic [DATA_WIDTH-1:0] r_bank0 [NumKnots];
   logic [DATA_WIDTH-1:0] r_bank1 [NumKnots];

   state_e r_state;
   logic   r_active;
   logic   r_commit_pending;
   logic   w_swap;
   logic   w_rd_bank;
   logic   w_wr_ok;

   // The swap pixel already reads the incoming bank.
   assign w_swap    = (r_state == StPending) && bus.inpvalid && bus.sof;
   assign w_rd_bank = r_active ^ w_swap;
   assign w_wr_ok   = bus.lut_wr && !r_commit_pending &&
                      (bus.lut_addr <= ADDR_WIDTH'(NumKnots - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state          <= StIdle;
         r_active         <= 1'b0;
         r_commit_pending <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (bus.lut_commit) begin
                  r_state          <= StPending;
                  r_commit_pending <= 1'b1;
               end
            end
            StPending: begin
               if (w_swap) begin
                  r_state          <= StIdle;
                  r_active         <= ~r_active;
                  r_commit_pending <= 1'b0;
               end
            end
            default: begin
               r_state          <= StIdle;
               r_commit_pending <= 1'b0;
            end
         endcase
      end
   end

   // Writes never coincide with a swap: they are blocked while a commit is pending.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < NumKnots; i++) begin
            r_bank0[i] <= ident_knot(i);
            r_bank1[i] <= ident_knot(i);
         end
      end else if (w_wr_ok) begin
         if (r_active) r_bank0[bus.lut_addr] <= bus.lut_wdata;
         else          r_bank1[bus.lut_addr] <= bus.lut_wdata;
      end
   end

   logic        [DATA_WIDTH-1:0] w_din   [3];
   logic        [ADDR_WIDTH-1:0] w_lo    [3];
   logic        [ADDR_WIDTH-1:0] w_hi    [3];
   logic        [DATA_WIDTH-1:0] w_k0    [3];
   logic        [DATA_WIDTH-1:0] w_k1    [3];
   logic signed [DW-1:0]         w_d     [3];
   logic signed [PW-1:0]         w_p     [3];
   logic signed [YW-1:0]         w_rnd   [3];
   logic signed [YW-1:0]         w_sh    [3];
   logic signed [YW-1:0]         w_y     [3];
   logic        [DATA_WIDTH-1:0] w_sat   [3];

   logic                         r_s1_valid;
   logic        [FRAC_BITS-1:0]  r_s1_frac [3];
   logic        [DATA_WIDTH-1:0] r_s1_k0   [3];
   logic        [DATA_WIDTH-1:0] r_s1_k1   [3];
   logic                         r_s2_valid;
   logic signed [PW-1:0]         r_s2_p    [3];
   logic        [DATA_WIDTH-1:0] r_s2_k0   [3];
   logic                         r_outvalid;
   logic        [DATA_WIDTH-1:0] r_dout    [3];

   assign w_din[0] = bus.din0;
   assign w_din[1] = bus.din1;
   assign w_din[2] = bus.din2;

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         w_lo[p] = ADDR_WIDTH'(w_din[p][DATA_WIDTH-1:FRAC_BITS]);
         w_hi[p] = w_lo[p] + ADDR_WIDTH'(1);
         w_k0[p] = w_rd_bank ? r_bank1[w_lo[p]] : r_bank0[w_lo[p]];
         w_k1[p] = w_rd_bank ? r_bank1[w_hi[p]] : r_bank0[w_hi[p]];

         w_d[p]  = {1'b0, r_s1_k1[p]} - {1'b0, r_s1_k0[p]};
         w_p[p]  = {{(PW - DW){w_d[p][DW-1]}}, w_d[p]} *
                   {{(PW - FRAC_BITS){1'b0}}, r_s1_frac[p]};

         // Round half up, then floor via arithmetic shift so negative slopes round consistently.
         w_rnd[p] = {{(YW - PW){r_s2_p[p][PW-1]}}, r_s2_p[p]} + YW'(RndInt);
         w_sh[p]  = w_rnd[p] >>> FRAC_BITS;
         w_y[p]   = w_sh[p] + {{(YW - DATA_WIDTH){1'b0}}, r_s2_k0[p]};

         if (w_y[p][YW-1])                       w_sat[p] = '0;
         else if (|w_y[p][YW-2:DATA_WIDTH])      w_sat[p] = '1;
         else                                    w_sat[p] = w_y[p][DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_outvalid <= 1'b0;
         for (int p = 0; p < 3; p++) begin
            r_s1_frac[p] <= '0;
            r_s1_k0[p]   <= '0;
            r_s1_k1[p]   <= '0;
            r_s2_p[p]    <= '0;
            r_s2_k0[p]   <= '0;
            r_dout[p]    <= '0;
         end
      end else begin
         r_s1_valid <= bus.inpvalid;
         r_s2_valid <= r_s1_valid;
         r_outvalid <= r_s2_valid;
         for (int p = 0; p < 3; p++) begin
            if (bus.inpvalid) begin
               r_s1_frac[p] <= w_din[p][FRAC_BITS-1:0];
               r_s1_k0[p]   <= w_k0[p];
               r_s1_k1[p]   <= w_k1[p];
            end
            if (r_s1_valid) begin
               r_s2_p[p]  <= w_p[p];
               r_s2_k0[p] <= r_s1_k0[p];
            end
            if (r_s2_valid) r_dout[p] <= w_sat[p];
         end
      end
   end

   assign bus.outvalid       = r_outvalid;
   assign bus.dout0          = r_dout[0];
   assign bus.dout1          = r_dout[1];
   assign bus.dout2          = r_dout[2];
   assign bus.commit_pending = r_commit_pending;
endmodule

// File: tb/tb_degamma_linearizer.sv
// Randomised bench for degamma_linearizer against a curve-table model with a timed result queue.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_degamma_linearizer;
   logic clk  = 1'b0;
   logic rstn = 1'b0;

   always #5 clk = ~clk;

   degamma_linearizer_if #(.DATA_WIDTH(12), .ADDR_WIDTH(7)) bus ();

   degamma_linearizer #(
      .DATA_WIDTH(12),
      .FRAC_BITS (6),
      .ADDR_WIDTH(7)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   typedef struct {
      int due;
      int y0;
      int y1;
      int y2;
   } exp_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   m_bank [2][65];
   int   m_active;
   bit   m_pending;
   exp_t q [$];
   bit   exp_v;
   int   exp_y [3];

   function automatic int lin(input int b, input int x);
      int seg, f, k0, k1, p, y;
      seg = x / 64;
      f   = x % 64;
      k0  = m_bank[b][seg];
      k1  = m_bank[b][seg + 1];
      p   = (k1 - k0) * f;
      y   = k0 + ((p + 32) >>> 6);
      if (y < 0) y = 0;
      if (y > 4095) y = 4095;
      return y;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 65; i++) begin
         m_bank[0][i] = (i * 64 > 4095) ? 4095 : i * 64;
         m_bank[1][i] = m_bank[0][i];
      end
      m_active  = 0;
      m_pending = 1'b0;
      q.delete();
      exp_v = 1'b0;
      exp_y = '{0, 0, 0};
   endfunction

   function automatic logic [37:0] exp_vec();
      return {exp_v, 12'(exp_y[0]), 12'(exp_y[1]), 12'(exp_y[2]), m_pending};
   endfunction

   function automatic logic [37:0] act_vec();
      return {bus.outvalid, bus.dout0, bus.dout1, bus.dout2, bus.commit_pending};
   endfunction

   task automatic idle();
      bus.inpvalid   = 1'b0;
      bus.sof        = 1'b0;
      bus.din0       = '0;
      bus.din1       = '0;
      bus.din2       = '0;
      bus.lut_wr     = 1'b0;
      bus.lut_addr   = '0;
      bus.lut_wdata  = '0;
      bus.lut_commit = 1'b0;
   endtask

   task automatic set_pix(input bit v, input bit s, input int d0, input int d1, input int d2);
      bus.inpvalid = v;
      bus.sof      = s;
      bus.din0     = 12'(d0);
      bus.din1     = 12'(d1);
      bus.din2     = 12'(d2);
   endtask

   // Advance one clock, applying the curve/commit rules to the inputs seen at the edge.
   task automatic step();
      bit   swap;
      int   rd;
      int   a;
      exp_t e;
      @(posedge clk);
      swap = m_pending && bus.inpvalid && bus.sof;
      rd   = swap ? 1 - m_active : m_active;
      cyc++;
      if (bus.inpvalid) begin
         e.due = cyc + 2;
         e.y0  = lin(rd, int'(bus.din0));
         e.y1  = lin(rd, int'(bus.din1));
         e.y2  = lin(rd, int'(bus.din2));
         q.push_back(e);
      end
      a = int'(bus.lut_addr);
      if (bus.lut_wr && !m_pending && a <= 64) m_bank[1 - m_active][a] = int'(bus.lut_wdata);
      if (!m_pending) begin
         if (bus.lut_commit) m_pending = 1'b1;
      end else if (swap) begin
         m_active  = 1 - m_active;
         m_pending = 1'b0;
      end
      @(negedge clk);
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e        = q.pop_front();
         exp_v    = 1'b1;
         exp_y[0] = e.y0;
         exp_y[1] = e.y1;
         exp_y[2] = e.y2;
      end
   endtask

   task automatic write_knot(input int addr, input int data);
      bus.lut_wr    = 1'b1;
      bus.lut_addr  = 7'(addr);
      bus.lut_wdata = 12'(data);
      step();
      bus.lut_wr    = 1'b0;
   endtask

   task automatic pulse_commit();
      bus.lut_commit = 1'b1;
      step();
      bus.lut_commit = 1'b0;
   endtask

   task automatic send_one(input bit s, input int d0, input int d1, input int d2);
      set_pix(1'b1, s, d0, d1, d2);
      step();
      set_pix(1'b0, 1'b0, 0, 0, 0);
      step();
      step();
   endtask

   task automatic test_reset();
      idle();
      rstn = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (act_vec() !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_state got %h want %h", act_vec(), 38'd0);
      end
      rstn = 1'b1;
   endtask

   task automatic test_identity();
      send_one(1'b0, 0, 2048, 1000);
      n_checks++;
      if ({bus.outvalid, bus.dout0, bus.dout1, bus.dout2} !== {1'b1, 12'd0, 12'd2048, 12'd1000}) begin
         n_fail++;
         $display("FAIL identity_spot got v=%0b %0d/%0d/%0d want v=1 0/2048/1000",
                  bus.outvalid, bus.dout0, bus.dout1, bus.dout2);
      end
      send_one(1'b0, 4095, 4095, 4095);
      n_checks++;
      if ({bus.outvalid, bus.dout0} !== {1'b1, 12'd4094}) begin
         n_fail++;
         $display("FAIL identity_top got v=%0b %0d want v=1 4094", bus.outvalid, bus.dout0);
      end
      for (int i = 0; i < 60; i++) begin
         set_pix(($urandom_range(3, 0) != 0), 1'b0, $urandom_range(4095, 0),
                 $urandom_range(4095, 0), $urandom_range(4095, 0));
         step();
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL identity_rand cyc=%0d got %h want %h", cyc, act_vec(), exp_vec());
         end
      end
      idle();
      repeat (3) step();
   endtask

   task automatic test_invert();
      for (int i = 0; i < 65; i++) write_knot(i, 4095 - ((i * 64 > 4095) ? 4095 : i * 64));
      pulse_commit();
      n_checks++;
      if (bus.commit_pending !== 1'b1) begin
         n_fail++;
         $display("FAIL invert_pending got %0b want 1", bus.commit_pending);
      end
      send_one(1'b1, 0, 0, 0);
      n_checks++;
      if ({bus.outvalid, bus.dout0, bus.commit_pending} !== {1'b1, 12'd4095, 1'b0}) begin
         n_fail++;
         $display("FAIL invert_zero got v=%0b %0d cp=%0b want v=1 4095 cp=0",
                  bus.outvalid, bus.dout0, bus.commit_pending);
      end
      send_one(1'b0, 2048, 0, 0);
      n_checks++;
      if (bus.dout0 !== 12'd2047) begin
         n_fail++;
         $display("FAIL invert_mid got %0d want 2047", bus.dout0);
      end
      send_one(1'b0, 32, 0, 0);
      n_checks++;
      if (bus.dout0 !== 12'd4063) begin
         n_fail++;
         $display("FAIL invert_round got %0d want 4063", bus.dout0);
      end
   endtask

   task automatic test_slope();
      write_knot(32, 100);
      write_knot(33, 164);
      pulse_commit();
      send_one(1'b1, 2080, 2080, 0);
      n_checks++;
      if (bus.dout0 !== 12'd132 || act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL slope_pos got %0d (%h) want 132 (%h)", bus.dout0, act_vec(), exp_vec());
      end
      write_knot(32, 100);
      write_knot(33, 36);
      pulse_commit();
      send_one(1'b1, 2080, 2080, 4095);
      n_checks++;
      if (bus.dout0 !== 12'd68 || act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL slope_neg got %0d (%h) want 68 (%h)", bus.dout0, act_vec(), exp_vec());
      end
   endtask

   task automatic test_pending();
      for (int i = 0; i < 20; i++) write_knot($urandom_range(127, 0), $urandom_range(4095, 0));
      pulse_commit();
      for (int i = 0; i < 1000; i++) begin
         if (i % 7 == 3) set_pix(1'b0, 1'b1, 0, 0, 0);
         else set_pix(1'b1, 1'b0, $urandom_range(4095, 0), $urandom_range(4095, 0),
                      $urandom_range(4095, 0));
         bus.lut_wr     = ($urandom_range(1, 0) == 1);
         bus.lut_addr   = 7'($urandom_range(64, 0));
         bus.lut_wdata  = 12'($urandom_range(4095, 0));
         bus.lut_commit = (i == 500);
         step();
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL pending_hold cyc=%0d got %h want %h", cyc, act_vec(), exp_vec());
         end
      end
      idle();
      repeat (3) step();
      send_one(1'b1, $urandom_range(4095, 0), $urandom_range(4095, 0), $urandom_range(4095, 0));
      n_checks++;
      if (act_vec() !== exp_vec() || bus.commit_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL pending_swap got %h want %h", act_vec(), exp_vec());
      end
      for (int i = 0; i < 40; i++) write_knot($urandom_range(64, 0), $urandom_range(4095, 0));
      set_pix(1'b1, 1'b1, $urandom_range(4095, 0), $urandom_range(4095, 0),
              $urandom_range(4095, 0));
      bus.lut_commit = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         bus.lut_commit = 1'b0;
         set_pix(1'b1, (i == 6), $urandom_range(4095, 0), $urandom_range(4095, 0),
                 $urandom_range(4095, 0));
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL commit_with_sof cyc=%0d got %h want %h", cyc, act_vec(), exp_vec());
         end
      end
      idle();
      repeat (3) step();
      n_checks++;
      if (bus.commit_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL commit_with_sof_done got %0b want 0", bus.commit_pending);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++) write_knot($urandom_range(64, 0), $urandom_range(4095, 0));
      pulse_commit();
      for (int i = 0; i < 27; i++) begin
         if (i < 24) set_pix(1'b1, (i == 12), $urandom_range(4095, 0), $urandom_range(4095, 0),
                             $urandom_range(4095, 0));
         else idle();
         step();
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL back_to_back cyc=%0d got %h want %h", cyc, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      pulse_commit();
      for (int i = 0; i < 3; i++) begin
         set_pix(1'b1, 1'b0, $urandom_range(4095, 0), $urandom_range(4095, 0),
                 $urandom_range(4095, 0));
         step();
      end
      rstn = 1'b0;
      idle();
      #1;
      n_checks++;
      if (act_vec() !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_mid_state got %h want %h", act_vec(), 38'd0);
      end
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_mid_stray cyc=%0d got %h want %h", cyc, act_vec(), exp_vec());
         end
      end
      send_one(1'b0, 4095, 1000, 2048);
      n_checks++;
      if ({bus.outvalid, bus.dout0, bus.dout1, bus.dout2} !== {1'b1, 12'd4094, 12'd1000, 12'd2048}) begin
         n_fail++;
         $display("FAIL reset_mid_identity got v=%0b %0d/%0d/%0d want v=1 4094/1000/2048",
                  bus.outvalid, bus.dout0, bus.dout1, bus.dout2);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_invert();
      test_slope();
      test_pending();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
